// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong match sequencer (idle/serve/play/point/game over); optional PONG_AUTO_SERVE_EN
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 60,
    parameter int POINT_TICKS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       score_left,
    input  logic       score_right,
    output logic       ball_hold,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] points_left,
    output logic [3:0] points_right,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SERVE    = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_POINT    = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    localparam logic [3:0] WIN_PTS    = WIN_SCORE[3:0];
    localparam logic [7:0] SERVE_LOAD = SERVE_TICKS[7:0];
    localparam logic [7:0] POINT_LOAD = POINT_TICKS[7:0];

    logic       start_q;
    logic       start_edge;
    logic [7:0] tcnt;
    logic       tcnt_zero;
    logic       serve_go;
    logic       left_only;
    logic       right_only;
    logic       any_score;
    logic       match_won;

    // Previous start level; resets high so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b1;
        end else begin
            start_q <= start;
        end
    end

    // Decode edges, rally outcome and serve launch condition
    always_comb begin
        start_edge = start & ~start_q;
        tcnt_zero  = (tcnt == 8'd0);
        left_only  = score_left & ~score_right;
        right_only = score_right & ~score_left;
        any_score  = score_left | score_right;
        match_won  = (points_left == WIN_PTS) || (points_right == WIN_PTS);
`ifdef PONG_AUTO_SERVE_EN
        serve_go   = tcnt_zero;
`else
        // Presses arriving while the countdown is still running are simply lost
        serve_go   = tcnt_zero & start_edge;
`endif
    end

    // Match state machine with registered outputs and the shared tick down-counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ball_hold    <= 1'b1;
            ball_reset   <= 1'b0;
            serve_dir    <= 1'b0;
            points_left  <= 4'd0;
            points_right <= 4'd0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
            tcnt         <= 8'd0;
        end else begin
            // ball_reset is a single-cycle strobe, only raised on a SERVE entry
            ball_reset <= 1'b0;

            // Counter only runs in the two timed states and parks at zero
            if ((state == ST_SERVE || state == ST_POINT) && tick && !tcnt_zero) begin
                tcnt <= tcnt - 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    ball_hold <= 1'b1;
                    if (start_edge) begin
                        points_left  <= 4'd0;
                        points_right <= 4'd0;
                        serve_dir    <= 1'b0;
                        tcnt         <= SERVE_LOAD;
                        ball_reset   <= 1'b1;
                        state        <= ST_SERVE;
                    end
                end

                ST_SERVE: begin
                    ball_hold <= 1'b1;
                    if (serve_go) begin
                        ball_hold <= 1'b0;
                        state     <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    ball_hold <= 1'b0;
                    if (any_score) begin
                        // A simultaneous double score is a void rally: no point, same server
                        if (left_only) begin
                            if (points_left != WIN_PTS) begin
                                points_left <= points_left + 4'd1;
                            end
                            serve_dir <= 1'b1;
                        end else if (right_only) begin
                            if (points_right != WIN_PTS) begin
                                points_right <= points_right + 4'd1;
                            end
                            serve_dir <= 1'b0;
                        end
                        ball_hold <= 1'b1;
                        tcnt      <= POINT_LOAD;
                        state     <= ST_POINT;
                    end
                end

                ST_POINT: begin
                    ball_hold <= 1'b1;
                    if (tcnt_zero) begin
                        if (match_won) begin
                            game_over <= 1'b1;
                            winner    <= (points_right == WIN_PTS);
                            state     <= ST_GAMEOVER;
                        end else begin
                            tcnt       <= SERVE_LOAD;
                            ball_reset <= 1'b1;
                            state      <= ST_SERVE;
                        end
                    end
                end

                ST_GAMEOVER: begin
                    ball_hold <= 1'b1;
                    game_over <= 1'b1;
                    if (start_edge) begin
                        points_left  <= 4'd0;
                        points_right <= 4'd0;
                        serve_dir    <= 1'b0;
                        game_over    <= 1'b0;
                        winner       <= 1'b0;
                        tcnt         <= SERVE_LOAD;
                        ball_reset   <= 1'b1;
                        state        <= ST_SERVE;
                    end
                end

                default: begin
                    // Unused encodings fall back to a safe, held idle
                    ball_hold <= 1'b1;
                    game_over <= 1'b0;
                    winner    <= 1'b0;
                    tcnt      <= 8'd0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
